axis_serializer: RTL and testbench
==================================

// Module: axis_serializer
// PURPOSE
//  Width-down converter for AXI-Stream style valid/ready links.
//  - Accepts one wide word of DATA_NB lanes on the upstream port.
//  - Emits the lanes one per beat on the narrow downstream port, lane 0 first.
//  - Sits between a wide producer (e.g. packed memory reads) and a narrow consumer.
//  - Full throughput with no bubbles: one downstream beat per cycle while down_ready is high.
// PARAMETERS
//  DATA_NB     3  number of lanes per upstream word; must be >= 1
//  DATA_WIDTH  8  bits per lane, which is also the downstream data width
// PORTS
//  clk         in   1                    single clock; all state updates on posedge
//  rst         in   1                    asynchronous, active-high reset
//  up_data     in   DATA_NB*DATA_WIDTH   wide word; lane i = up_data[i*DATA_WIDTH +: DATA_WIDTH]
//  up_valid    in   1                    upstream word valid
//  up_ready    out  1                    serializer can take a word this cycle
//  down_data   out  DATA_WIDTH           current lane
//  down_valid  out  1                    down_data valid
//  down_ready  in   1                    consumer accepts the current lane
// BEHAVIOUR
//  - Handshakes:
//    - Upstream transfer when up_valid & up_ready at posedge clk.
//    - Downstream beat when down_valid & down_ready at posedge clk.
//  - Internal state:
//    - serial_data: DATA_NB*DATA_WIDTH holding/shift register.
//    - serial_valid: holding register is occupied.
//    - token: DATA_NB-bit one-hot lane pointer; bit k set means lane k is presented.
//  - Outputs:
//    - down_data = lane selected by token, driven from registers (no combinational path from up_data).
//    - down_valid = serial_valid.
//    - up_ready = ~rst & (~serial_valid | (down_ready & token[DATA_NB-1])), combinational.
//  - Load: an upstream transfer copies up_data into serial_data, sets serial_valid=1 and token=1 (lane 0).
//    The first lane is presented on the cycle after the transfer.
//  - Advance: a downstream beat with token[DATA_NB-1]=0 shifts token left by one.
//  - Last lane: a downstream beat with token[DATA_NB-1]=1:
//    - simultaneous upstream transfer: reload (the load rule wins);
//    - otherwise: serial_valid->0, token->1.
//  - Stall: while down_ready=0, down_data, down_valid and token hold. up_ready=0 while a word is held.
//  - DATA_NB=1: token is permanently 1 and every down beat is the last lane, so the block is a 1-deep register slice.
//  - Reset, async assert, including mid-word:
//    - serial_valid=0, token=1, serial_data=0, so down_valid=0 and down_data=0.
//    - Any partially sent word is discarded.
//    - up_ready is held 0 while rst is high and becomes 1 in the first cycle after release.
//  - Steady state with up_valid=1 and down_ready=1: up_ready pulses once every DATA_NB cycles; down_valid stays 1.
// TESTING
//  - Reset: pulse rst for 6 cycles with up_valid=1 -> down_valid=0, down_data=0, up_ready=0 during rst, up_ready=1 after release.
//  - Continuous: DATA_NB=3, W=8, word n = {3n+3,3n+2,3n+1}, up_valid=1, down_ready=1 for 20 cycles
//    -> down_data 1,2,3,4,5,6... one per cycle, no gaps; up_ready high 1 of every 3 cycles.
//  - Stall: drop down_ready mid-word (e.g. while presenting 5) for 10 cycles -> down_data stays 5, down_valid=1, up_ready=0;
//    on resume the sequence continues 5,6,7 with no loss or duplication.
//  - Sparse ready: single-cycle down_ready pulses separated by idle cycles -> exactly one lane advances per pulse, in order.
//  - Word boundary: down_ready=1 on lane 2 with up_valid=1 -> next cycle shows lane 0 of the next word; no bubble.
//  - Mid-word reset: assert rst while lane 1 is presented -> down_valid=0 immediately;
//    after release, the next accepted word starts at lane 0.

Source files
------------

// File: rtl/axis_serializer.sv
// axis_serializer: wide-to-narrow AXI-Stream width converter.
// A wide word of DATA_NB lanes is captured in one handshake and replayed one
// lane per beat downstream, lane 0 first, with back-to-back words and no
// bubbles when the consumer never stalls.

// Per-lane holding register. Its output is zeroed unless this lane is the one
// the token points at, so the top can OR the lanes together into down_data.
module axis_serializer_lane #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  sel,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] q;

  // capture the lane on every upstream transfer; cleared on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q <= '0;
    else if (load) q <= din;
  end

  assign dout = sel ? q : '0;

endmodule

module axis_serializer #(
  parameter int DATA_NB    = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_NB*DATA_WIDTH-1:0] up_data,
  input  logic                          up_valid,
  output logic                          up_ready,
  output logic [DATA_WIDTH-1:0]         down_data,
  output logic                          down_valid,
  input  logic                          down_ready
);

  // Holding register occupancy: EMPTY takes a word, FULL replays its lanes.
  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

  localparam logic [DATA_NB-1:0] TOKEN_LANE0 = DATA_NB'(1);

  state_t                                state_q, state_d;
  logic [DATA_NB-1:0]                    token_q, token_d;
  logic [DATA_NB-1:0][DATA_WIDTH-1:0]    lane_in;
  logic [DATA_NB-1:0][DATA_WIDTH-1:0]    lane_out;
  logic                                  serial_valid;
  logic                                  last_lane;
  logic                                  up_xfer;
  logic                                  down_beat;

  assign serial_valid = (state_q == S_FULL);
  assign last_lane    = token_q[DATA_NB-1];
  assign down_beat    = serial_valid & down_ready;
  assign up_xfer      = up_valid & up_ready;

  // A new word can enter when empty, or when the last lane leaves this cycle,
  // which is what keeps back-to-back words bubble-free.
  assign up_ready   = ~rst & (~serial_valid | (down_ready & last_lane));
  assign down_valid = serial_valid;

  // Lane registers, one instance per lane, all loaded together.
  for (genvar k = 0; k < DATA_NB; k++) begin : g_lane
    assign lane_in[k] = up_data[k*DATA_WIDTH +: DATA_WIDTH];

    axis_serializer_lane #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .load (up_xfer),
      .din  (lane_in[k]),
      .sel  (token_q[k]),
      .dout (lane_out[k])
    );
  end

  // down_data: OR of the masked lanes; only the token-selected lane is nonzero.
  always_comb begin
    down_data = '0;
    for (int k = 0; k < DATA_NB; k++) down_data = down_data | lane_out[k];
  end

  // State and token registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_EMPTY;
      token_q <= TOKEN_LANE0;
    end else begin
      state_q <= state_d;
      token_q <= token_d;
    end
  end

  // Next state / token: a load always wins over the last-lane drain.
  always_comb begin
    state_d = state_q;
    token_d = token_q;
    if (up_xfer) begin
      state_d = S_FULL;
      token_d = TOKEN_LANE0;
    end else if (down_beat) begin
      if (last_lane) begin
        state_d = S_EMPTY;
        token_d = TOKEN_LANE0;
      end else begin
        token_d = token_q << 1;
      end
    end
  end

endmodule

// File: tb/tb_axis_serializer.sv
// Bench for axis_serializer: the reference model is a queue of lanes still
// owed downstream; the driver pushes a word's lanes on each upstream
// handshake, and an independent negedge monitor checks outputs against it.
module tb_axis_serializer;

  localparam int NB = 3;
  localparam int W  = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NB*W-1:0] up_data = '0;
  logic            up_valid = 1'b0;
  logic            up_ready;
  logic [W-1:0]    down_data;
  logic            down_valid;
  logic            down_ready = 1'b0;

  int compared   = 0;
  int mismatched = 0;

  logic [W-1:0] exp_q[$];

  axis_serializer #(
    .DATA_NB    (NB),
    .DATA_WIDTH (W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .up_data    (up_data),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .down_data  (down_data),
    .down_valid (down_valid),
    .down_ready (down_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: the model says a lane is presented iff lanes are owed; a new word
  // may enter iff nothing is owed or only the final lane is owed and leaves now.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_down_valid", {31'd0, down_valid}, 32'd0);
      check("rst_down_data", {24'd0, down_data}, 32'd0);
      check("rst_up_ready", {31'd0, up_ready}, 32'd0);
    end else begin
      check("down_valid", {31'd0, down_valid}, {31'd0, exp_q.size() > 0});
      check("up_ready", {31'd0, up_ready},
            {31'd0, (exp_q.size() == 0) || (down_ready && exp_q.size() == 1)});
      if (down_valid && exp_q.size() > 0) begin
        check("down_data", {24'd0, down_data}, {24'd0, exp_q[0]});
        if (down_ready) void'(exp_q.pop_front());
      end
    end
  end

  function automatic logic [NB*W-1:0] word(input int n);
    logic [NB*W-1:0] w;
    for (int k = 0; k < NB; k++) w[k*W +: W] = W'(NB*n + k + 1);
    return w;
  endfunction

  // One clock: drive at posedge+1, decide handshake at negedge, record at posedge.
  task automatic step(input logic uv, input logic [NB*W-1:0] d, input logic dr,
                      output logic hs);
    up_valid = uv; up_data = d; down_ready = dr;
    @(negedge clk);
    hs = up_valid && up_ready && !rst;
    @(posedge clk);
    if (hs) for (int k = 0; k < NB; k++) exp_q.push_back(d[k*W +: W]);
    #1;
  endtask

  task automatic reset_pulse(input int cycles);
    logic hs;
    rst = 1'b1;
    exp_q.delete();
    for (int i = 0; i < cycles; i++) step(1'b1, word(100 + i), 1'b1, hs);
    rst = 1'b0;
  endtask

  // Watchdog: every phase is bounded, this only catches a stuck simulator.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic hs;
    int n;
    @(posedge clk); #1;
    reset_pulse(6);

    // continuous: 1,2,3,4,... one per cycle
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, word(n), 1'b1, hs);
      if (hs) n++;
    end
    // stall mid-word for 10 cycles, then resume
    for (int i = 0; i < 10; i++) begin
      step(1'b1, word(n), 1'b0, hs);
      if (hs) n++;
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b1, word(n), 1'b1, hs);
      if (hs) n++;
    end
    // sparse ready pulses with idle gaps
    for (int i = 0; i < 12; i++) begin
      step(1'b1, word(n), 1'b1, hs);
      if (hs) n++;
      step(1'b1, word(n), 1'b0, hs);
      if (hs) n++;
      step(1'b0, word(n), 1'b0, hs);
    end
    // drain, then mid-word reset while lane 1 is presented
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, hs);
    step(1'b1, word(50), 1'b1, hs);   // load
    step(1'b0, '0, 1'b1, hs);         // lane 0 leaves
    step(1'b0, '0, 1'b0, hs);         // lane 1 presented, held
    reset_pulse(3);
    n = 60;
    for (int i = 0; i < 9; i++) begin
      step(1'b1, word(n), 1'b1, hs);
      if (hs) n++;
    end

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 3) != 0), NB*W'($urandom()) ^ {NB{W'($urandom())}},
           ($urandom_range(0, 9) < 7), hs);
      if ($urandom_range(0, 499) == 0) reset_pulse($urandom_range(1, 3));
    end
    // final drain: every owed lane must come out
    for (int i = 0; i < 4 * NB && exp_q.size() > 0; i++) step(1'b0, '0, 1'b1, hs);
    check("drain_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
